// File: rtl/arb_req_client.sv
// Requester-side agent for a two-way round-robin arbiter: queues producer jobs,
// holds a registered req per job, and issues one beat per granted cycle.
module arb_req_client #(
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [LEN_W-1:0]       job_len,
   output logic                   req,
   input  logic                   gnt,
   output logic                   beat,
   output logic [LEN_W-1:0]       beat_idx,
   output logic                   done,
   output logic                   starve,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               push, pop;
   logic [LEN_W-1:0]   len_r, len_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
   logic               req_nxt, done_nxt, starve_nxt;

   assign job_ready = (count != CNT_W'(DEPTH));
   assign push      = job_valid & job_ready;
   assign q_count   = count;
   assign beat      = (state == REQ) & gnt;
   assign beat_idx  = cnt;

   // Job queue occupancy; a simultaneous push and pop cancel out.
   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_W'(1);
      end else if (!push && pop) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= job_len;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count_nxt;
      end
   end

   // Next-state, beat counter and wait counter.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      len_nxt   = len_r;
      cnt_nxt   = cnt;
      wait_nxt  = '0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               len_nxt   = mem[rd_ptr];
               cnt_nxt   = '0;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (gnt) begin
               if (cnt == len_r) begin
                  state_nxt = GAP;
               end else begin
                  cnt_nxt = cnt + LEN_W'(1);
               end
            end else begin
               wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + WAIT_W'(1);
            end
         end
         GAP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      req_nxt    = (state_nxt == REQ);
      done_nxt   = (state_nxt == GAP);
      starve_nxt = starve | (wait_cnt >= WAIT_W'(MAX_WAIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_r    <= '0;
         cnt      <= '0;
         wait_cnt <= '0;
         req      <= 1'b0;
         done     <= 1'b0;
         starve   <= 1'b0;
      end else begin
         state    <= state_nxt;
         len_r    <= len_nxt;
         cnt      <= cnt_nxt;
         wait_cnt <= wait_nxt;
         req      <= req_nxt;
         done     <= done_nxt;
         starve   <= starve_nxt;
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
   a_req_state   : assert property (@(posedge clk) disable iff (rst) req == (state == REQ));
   a_beat_gated  : assert property (@(posedge clk) disable iff (rst) beat |-> req);

endmodule

// File: tb/tb_arb_req_client.sv
// Bench for arb_req_client: vector table, hand-written corner sequences and a
// randomized run, all checked against a job-level reference model.
module tb_arb_req_client;

   localparam int unsigned LEN_W    = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned MAX_WAIT = 15;
   localparam int unsigned WAIT_W   = 4;
   localparam int unsigned CNT_W    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             job_valid, job_ready, req, gnt, beat, done, starve;
   logic [LEN_W-1:0] job_len, beat_idx;
   logic [CNT_W-1:0] q_count;
   logic             job_valid_b, job_ready_b, req_b, gnt_b, beat_b, done_b, starve_b;
   logic [LEN_W-1:0] job_len_b, beat_idx_b;
   logic [CNT_W-1:0] q_count_b;

   always #5 clk = ~clk;

   arb_req_client #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
      .req(req), .gnt(gnt), .beat(beat), .beat_idx(beat_idx), .done(done), .starve(starve),
      .q_count(q_count));

   arb_req_client #(.LEN_W(LEN_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut_b (
      .clk(clk), .rst(rst), .job_valid(job_valid_b), .job_ready(job_ready_b), .job_len(job_len_b),
      .req(req_b), .gnt(gnt_b), .beat(beat_b), .beat_idx(beat_idx_b), .done(done_b),
      .starve(starve_b), .q_count(q_count_b));

   int n_vec = 0;
   int n_err = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of job lengths plus the progress of the active job.
   int mq[$];
   bit m_active, m_cool, m_starve;
   int m_len, m_beats, m_wait;

   function automatic void model_reset();
      mq.delete();
      m_active = 0;
      m_cool   = 0;
      m_starve = 0;
      m_len    = 0;
      m_beats  = 0;
      m_wait   = 0;
   endfunction

   function automatic void model_step(input bit jv, input int jl, input bit g);
      bit accept;
      accept = jv && (mq.size() < DEPTH);
      if (m_wait >= MAX_WAIT) m_starve = 1;
      if (m_active) begin
         if (g) begin
            m_wait = 0;
            m_beats++;
            if (m_beats > m_len) begin
               m_active = 0;
               m_cool   = 1;
            end
         end else if (m_wait < (1 << WAIT_W) - 1) begin
            m_wait++;
         end
      end else if (m_cool) begin
         m_cool = 0;
      end else if (mq.size() > 0) begin
         m_len    = mq.pop_front();
         m_beats  = 0;
         m_active = 1;
      end
      if (accept) mq.push_back(jl);
   endfunction

   task automatic check_model(input bit g);
      cmp("m_req", req, m_active);
      cmp("m_beat", beat, m_active && g);
      if (m_active && g) cmp("m_beat_idx", beat_idx, m_beats);
      cmp("m_done", done, m_cool);
      cmp("m_q_count", q_count, mq.size());
      cmp("m_job_ready", job_ready, mq.size() < DEPTH);
      cmp("m_starve", starve, m_starve);
   endtask

   // Entered and left at posedge+1.
   task automatic apply(input bit jv, input int jl, input bit g);
      job_valid = jv;
      job_len   = LEN_W'(jl);
      gnt       = g;
      #1;
      check_model(g);
      @(posedge clk);
      model_step(jv, jl, g);
      #1;
   endtask

   typedef struct {
      bit jv; int jl; bit g;
      bit req; bit beat; int idx; bit done; int qc; bit rdy;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input bit jv, input int jl, input bit g, input bit r,
                               input bit b, input int idx, input bit d, input int qc, input bit rdy);
      vec_t v;
      v.jv = jv; v.jl = jl; v.g = g; v.req = r; v.beat = b; v.idx = idx;
      v.done = d; v.qc = qc; v.rdy = rdy;
      tbl.push_back(v);
   endfunction

   initial begin
      int lens[$];
      int exp_lens[5];
      int cur, rise, st;
      bit found;
      bit last_b, pra, prb, seena, seenb, ga, gb;
      int lowa, lowb, gacnt, gbcnt;
      int own[$];

      rst = 1'b1;
      job_valid = 0; job_len = '0; gnt = 0;
      job_valid_b = 0; job_len_b = '0; gnt_b = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp("rst_req", req, 0);
      cmp("rst_done", done, 0);
      cmp("rst_starve", starve, 0);
      cmp("rst_q_count", q_count, 0);
      cmp("rst_job_ready", job_ready, 1);
      cmp("rst_beat", beat, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single job len 3, gnt tied high
      add(1,3,1, 0,0,0,0,0,1);
      add(0,0,1, 0,0,0,0,1,1);
      add(0,0,1, 1,1,0,0,0,1);
      add(0,0,1, 1,1,1,0,0,1);
      add(0,0,1, 1,1,2,0,0,1);
      add(0,0,1, 1,1,3,0,0,1);
      add(0,0,1, 0,0,0,1,0,1);
      add(0,0,0, 0,0,0,0,0,1);
      // len 2 with grant pattern 1,0,0,1,1; gnt in IDLE/GAP ignored
      add(1,2,0, 0,0,0,0,0,1);
      add(0,0,1, 0,0,0,0,1,1);
      add(0,0,1, 1,1,0,0,0,1);
      add(0,0,0, 1,0,0,0,0,1);
      add(0,0,0, 1,0,0,0,0,1);
      add(0,0,1, 1,1,1,0,0,1);
      add(0,0,1, 1,1,2,0,0,1);
      add(0,0,1, 0,0,0,1,0,1);
      add(0,0,1, 0,0,0,0,0,1);
      // push into empty queue during GAP, popped in the following IDLE
      add(1,0,1, 0,0,0,0,0,1);
      add(0,0,1, 0,0,0,0,1,1);
      add(0,0,1, 1,1,0,0,0,1);
      add(1,1,1, 0,0,0,1,0,1);
      add(0,0,1, 0,0,0,0,1,1);
      add(0,0,1, 1,1,0,0,0,1);
      add(0,0,1, 1,1,1,0,0,1);
      add(0,0,0, 0,0,0,1,0,1);
      add(0,0,0, 0,0,0,0,0,1);

      foreach (tbl[i]) begin
         job_valid = tbl[i].jv;
         job_len   = LEN_W'(tbl[i].jl);
         gnt       = tbl[i].g;
         #1;
         cmp($sformatf("tbl%0d_req", i), req, tbl[i].req);
         cmp($sformatf("tbl%0d_beat", i), beat, tbl[i].beat);
         if (tbl[i].beat) cmp($sformatf("tbl%0d_idx", i), beat_idx, tbl[i].idx);
         cmp($sformatf("tbl%0d_done", i), done, tbl[i].done);
         cmp($sformatf("tbl%0d_qc", i), q_count, tbl[i].qc);
         cmp($sformatf("tbl%0d_rdy", i), job_ready, tbl[i].rdy);
         check_model(tbl[i].g);
         @(posedge clk);
         model_step(tbl[i].jv, tbl[i].jl, tbl[i].g);
         #1;
      end

      // two clients behind a round-robin arbiter, 2 jobs of len 0 each
      last_b = 1; pra = 0; prb = 0; seena = 0; seenb = 0;
      lowa = 0; lowb = 0; gacnt = 0; gbcnt = 0;
      for (int k = 0; k < 14; k++) begin
         ga = 0; gb = 0;
         if (req && req_b) begin
            if (last_b) ga = 1; else gb = 1;
         end else if (req) begin
            ga = 1;
         end else if (req_b) begin
            gb = 1;
         end
         if (ga) begin last_b = 0; own.push_back(0); gacnt++; end
         if (gb) begin last_b = 1; own.push_back(1); gbcnt++; end
         if (req && !pra && seena) cmp("arb_gap_a", lowa >= 2, 1);
         if (req_b && !prb && seenb) cmp("arb_gap_b", lowb >= 2, 1);
         if (req) begin seena = 1; lowa = 0; end else lowa++;
         if (req_b) begin seenb = 1; lowb = 0; end else lowb++;
         pra = req; prb = req_b;
         job_valid_b = (k < 2);
         job_len_b   = '0;
         gnt_b       = gb;
         gnt         = ga;
         #1;
         cmp("arb_beat_b", beat_b, gb);
         if (gb) cmp("arb_idx_b", beat_idx_b, 0);
         apply(k < 2, 0, ga);
      end
      gnt_b = 0; job_valid_b = 0;
      cmp("arb_grants_a", gacnt, 2);
      cmp("arb_grants_b", gbcnt, 2);
      for (int i = 1; i < own.size(); i++) cmp("arb_alternate", own[i] != own[i-1], 1);
      cmp("arb_starve_a", starve, 0);
      cmp("arb_starve_b", starve_b, 0);
      cmp("arb_qc_b", q_count_b, 0);
      cmp("arb_rdy_b", job_ready_b, 1);
      cmp("arb_done_b", done_b, 0);

      // queue full with gnt withheld, then drain in order
      apply(1, 1, 0);
      apply(1, 2, 0);
      apply(1, 3, 0);
      apply(1, 0, 0);
      cmp("qfull_cnt3", q_count, 3);
      apply(1, 5, 0);
      cmp("qfull_cnt4", q_count, 4);
      cmp("qfull_ready0", job_ready, 0);
      apply(1, 7, 0);
      cmp("qfull_ignored", q_count, 4);
      exp_lens = '{2, 3, 4, 1, 6};
      cur = 0;
      for (int k = 0; k < 80 && lens.size() < 5; k++) begin
         job_valid = 0; gnt = 1;
         #1;
         check_model(1);
         if (beat) cur++;
         if (done) begin lens.push_back(cur); cur = 0; end
         @(posedge clk);
         model_step(0, 0, 1);
         #1;
      end
      cmp("drain_jobs", lens.size(), 5);
      for (int i = 0; i < lens.size() && i < 5; i++) cmp($sformatf("drain_len%0d", i), lens[i], exp_lens[i]);
      repeat (2) apply(0, 0, 0);

      // starvation latency and stickiness
      apply(1, 0, 0);
      rise = -1; st = -1;
      for (int k = 0; k < 30; k++) begin
         job_valid = 0; gnt = 0;
         #1;
         check_model(0);
         if (req && rise < 0) rise = k;
         if (starve && st < 0) st = k;
         @(posedge clk);
         model_step(0, 0, 0);
         #1;
      end
      cmp("starve_seen", (rise >= 0) && (st >= 0), 1);
      cmp("starve_latency", st - rise, 16);
      repeat (4) apply(0, 0, 1);
      cmp("starve_sticky", starve, 1);

      // async reset in the middle of a len 5 job with two queued
      apply(1, 5, 1);
      apply(1, 1, 1);
      apply(1, 2, 1);
      found = 0;
      for (int k = 0; k < 10; k++) begin
         job_valid = 0; gnt = 1;
         #1;
         check_model(1);
         if (beat && beat_idx == 2) begin found = 1; break; end
         @(posedge clk);
         model_step(0, 0, 1);
         #1;
      end
      cmp("rst_wait_found", found, 1);
      cmp("pre_rst_qc", q_count, 2);
      rst = 1'b1;
      #1;
      cmp("arst_req", req, 0);
      cmp("arst_beat", beat, 0);
      cmp("arst_done", done, 0);
      cmp("arst_q_count", q_count, 0);
      cmp("arst_starve", starve, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(1, 2, 1);
      apply(0, 0, 1);
      job_valid = 0; gnt = 1;
      #1;
      cmp("post_rst_beat", beat, 1);
      cmp("post_rst_idx", beat_idx, 0);
      check_model(1);
      @(posedge clk);
      model_step(0, 0, 1);
      #1;

      // randomized traffic, with a stretch of near-zero grant rate
      for (int k = 0; k < 3000; k++) begin
         int gp, jl;
         gp = (k >= 2000 && k < 2150) ? 3 : 70;
         jl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
         apply($urandom_range(0, 99) < 40, jl, $urandom_range(0, 99) < gp);
      end
      repeat (3) apply(0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
